// File: rtl/ext_ram_trace_tap.sv
// ext_ram_trace_tap: transparent external-RAM tap that records {address, data} pairs into a triggered circular trace buffer
// Ports: sys_clk, sys_rst (async, active-high); ext_ram_i_adr -> ext_ram_o_adr and ext_ram_o_dat_r -> ext_ram_i_dat_r
// pass straight through; arm/abort start or cancel a capture; trig_adr/trig_mask define the trigger; pre_count is the
// number of pre-trigger entries; state/done report progress; rd_idx (0 = oldest) selects the entry returned on rd_adr/rd_dat.
module ext_ram_trace_tap #(
  parameter int ADR_W = 32,
  parameter int DAT_W = 32,
  parameter int DEPTH_LOG2 = 9,
  parameter int DAT_LAT = 1,
  parameter int CHANGE_ONLY = 0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [ADR_W-1:0]      ext_ram_i_adr,
  output logic [DAT_W-1:0]      ext_ram_i_dat_r,
  output logic [ADR_W-1:0]      ext_ram_o_adr,
  input  logic [DAT_W-1:0]      ext_ram_o_dat_r,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [ADR_W-1:0]      trig_adr,
  input  logic [ADR_W-1:0]      trig_mask,
  input  logic [DEPTH_LOG2-1:0] pre_count,
  output logic [2:0]            state,
  output logic                  done,
  input  logic [DEPTH_LOG2-1:0] rd_idx,
  output logic [ADR_W-1:0]      rd_adr,
  output logic [DAT_W-1:0]      rd_dat
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef enum logic [2:0] {IDLE = 3'd0, PRE = 3'd1, WAIT = 3'd2, POST = 3'd3, DONE = 3'd4} state_t;
  state_t st, st_nxt;
  logic [ADR_W+DAT_W-1:0] mem [DEPTH];
  logic [ADR_W-1:0] adr_d, prev_a, a;
  logic prev_vld, q, hit, idle, arm_go, we;
  logic [DEPTH_LOG2-1:0] p, cnt, rem, wp, sp, rd_ptr;
  assign ext_ram_o_adr = ext_ram_i_adr;
  assign ext_ram_i_dat_r = ext_ram_o_dat_r;
  // with one cycle of RAM latency the data belongs to the previous cycle's address
  assign a = DAT_LAT != 0 ? adr_d : ext_ram_i_adr;
  assign q = CHANGE_ONLY == 0 || !prev_vld || a != prev_a;
  assign hit = ((a ^ trig_adr) & trig_mask) == '0;
  assign idle = st == IDLE || st == DONE;
  assign arm_go = arm && !abort && idle;
  assign we = q && !abort && !idle;
  assign rd_ptr = sp + rd_idx;
  assign state = st;
  assign done = st == DONE;
  always_comb begin
    st_nxt = st;
    if (abort) st_nxt = IDLE;
    else case (st)
      IDLE, DONE: if (arm) st_nxt = pre_count != '0 ? PRE : WAIT;
      PRE: if (q && cnt == p - DEPTH_LOG2'(1)) st_nxt = WAIT;
      WAIT: if (q && hit) st_nxt = &p ? DONE : POST;
      POST: if (q && rem == DEPTH_LOG2'(1)) st_nxt = DONE;
      default: st_nxt = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      st <= IDLE;
      adr_d <= '0;
      prev_a <= '0;
      prev_vld <= 1'b0;
      p <= '0;
      cnt <= '0;
      rem <= '0;
      wp <= '0;
      sp <= '0;
      rd_adr <= '0;
      rd_dat <= '0;
    end else begin
      st <= st_nxt;
      adr_d <= ext_ram_i_adr;
      prev_a <= a;
      // forgetting the history on arm makes the first post-arm sample always qualify
      prev_vld <= !arm_go;
      {rd_adr, rd_dat} <= mem[rd_ptr];
      if (arm_go) begin
        p <= pre_count;
        cnt <= '0;
        rem <= '0;
        wp <= '0;
      end
      if (we) begin
        wp <= wp + DEPTH_LOG2'(1);
        cnt <= cnt + DEPTH_LOG2'(1);
        // oldest kept entry sits P slots behind the trigger; ~p is DEPTH-1-P post-trigger entries
        if (st == WAIT && hit) begin
          sp <= wp - p;
          rem <= ~p;
        end
        if (st == POST) rem <= rem - DEPTH_LOG2'(1);
      end
    end
  always_ff @(posedge sys_clk)
    if (we) mem[wp] <= {a, ext_ram_o_dat_r};
endmodule

// File: tb/tb_ext_ram_trace_tap.sv
// tb_ext_ram_trace_tap: scoreboard bench for ext_ram_trace_tap with three configurations sharing one stimulus stream
module tb_ext_ram_trace_tap;
  localparam int DL = 4;
  localparam int DEPTH = 16;
  logic clk = 0, rst = 1, arm = 0, abort = 0;
  logic [31:0] adr = 0, dat = 0, trig_adr = 0, trig_mask = 0;
  logic [3:0] pre_count = 0, rd_idx = 0;
  logic [31:0] o_adr [3], i_dat [3], rd_adr [3], rd_dat [3];
  logic [2:0] st [3];
  logic done [3];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // instance 0: DAT_LAT=0; instance 1: CHANGE_ONLY=1; instance 2: DAT_LAT=1
  for (genvar g = 0; g < 3; g++) begin : gi
    ext_ram_trace_tap #(.ADR_W(32), .DAT_W(32), .DEPTH_LOG2(DL), .DAT_LAT(g == 2 ? 1 : 0),
                        .CHANGE_ONLY(g == 1 ? 1 : 0)) dut (
      .sys_clk(clk), .sys_rst(rst), .ext_ram_i_adr(adr), .ext_ram_i_dat_r(i_dat[g]),
      .ext_ram_o_adr(o_adr[g]), .ext_ram_o_dat_r(dat), .arm(arm), .abort(abort),
      .trig_adr(trig_adr), .trig_mask(trig_mask), .pre_count(pre_count), .state(st[g]),
      .done(done[g]), .rd_idx(rd_idx), .rd_adr(rd_adr[g]), .rd_dat(rd_dat[g]));
    // reference model: phase 0 idle, 1 capturing, 2 done; hist holds every qualified sample since arm
    int phase = 0, pp = 0, tix = -1;
    bit valid = 0, pvld = 0;
    logic [31:0] last = 0, pa = 0;
    logic [63:0] hist [$];
    logic [63:0] res [DEPTH];
    logic [2:0] exp_st [$];
    logic [63:0] exp_rd [$];
    function automatic logic [2:0] cur_state();
      return phase == 0 ? 3'd0 : phase == 2 ? 3'd4 : hist.size() < pp ? 3'd1 : tix < 0 ? 3'd2 : 3'd3;
    endfunction
    always @(posedge clk) begin
      logic [31:0] a;
      bit q, go;
      a = g == 2 ? last : adr;
      q = g != 1 || !pvld || a != pa;
      go = 0;
      if (rst) begin
        phase = 0;
        valid = 0;
        pvld = 0;
        last = 0;
        pa = 0;
        exp_rd.push_back(64'd0);
      end else begin
        if (valid && phase != 1) exp_rd.push_back(res[rd_idx]);
        if (abort) phase = 0;
        else if (arm && phase != 1) begin
          phase = 1;
          pp = int'(pre_count);
          hist.delete();
          tix = -1;
          valid = 0;
          go = 1;
        end else if (phase == 1 && q) begin
          hist.push_back({a, dat});
          if (tix < 0 && hist.size() > pp && ((a ^ trig_adr) & trig_mask) == 0) tix = hist.size() - 1;
          if (tix >= 0 && hist.size() == tix + DEPTH - pp) begin
            for (int i = 0; i < DEPTH; i++) res[i] = hist[tix - pp + i];
            phase = 2;
            valid = 1;
          end
        end
        last = adr;
        pa = a;
        pvld = !go;
      end
      exp_st.push_back(cur_state());
    end
    always @(negedge clk) begin
      logic [2:0] es;
      logic [63:0] er;
      if (exp_st.size() > 0) begin
        es = exp_st.pop_front();
        chk($sformatf("state[%0d]", g), 32'(st[g]), 32'(es));
        chk($sformatf("done[%0d]", g), 32'(done[g]), 32'(es == 3'd4));
      end
      if (exp_rd.size() > 0) begin
        er = exp_rd.pop_front();
        chk($sformatf("rd_adr[%0d]", g), rd_adr[g], er[63:32]);
        chk($sformatf("rd_dat[%0d]", g), rd_dat[g], er[31:0]);
      end
    end
  end
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic chk_pass(input string tag);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk({tag, " o_adr"}, o_adr[i], adr);
      chk({tag, " i_dat"}, i_dat[i], dat);
    end
  endtask
  task automatic ramp(input logic [31:0] base, input int n, input int hold);
    for (int k = 0; k < n; k++)
      for (int h = 0; h < hold; h++) begin
        dat = adr + 32'h100;
        adr = base + 32'(k);
        rd_idx = 4'($urandom_range(0, 15));
        step();
      end
  endtask
  task automatic start(input logic [3:0] pc, input logic [31:0] ta, input logic [31:0] tm);
    abort = 1;
    step();
    abort = 0;
    pre_count = pc;
    trig_adr = ta;
    trig_mask = tm;
    dat = adr + 32'h100;
    adr = 32'h3FF;
    arm = 1;
    step();
    arm = 0;
  endtask
  initial begin
    adr = 32'h1234;
    dat = 32'hCAFE;
    chk_pass("pass in reset");
    repeat (3) step();
    rst = 0;
    chk_pass("pass");
    step();
    start(4, 32'h20, '1);
    ramp(0, 60, 1);
    rd_idx = 0;
    step();
    chk("cap oldest", rd_adr[0], 32'h1C);
    rd_idx = 4;
    step();
    chk("cap trig adr", rd_adr[0], 32'h20);
    chk("lat1 trig adr", rd_adr[2], 32'h20);
    chk("lat1 trig dat", rd_dat[2], 32'h120);
    rd_idx = 15;
    step();
    chk("cap newest", rd_adr[0], 32'h2B);
    chk("cap done", 32'(done[0]), 32'd1);
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      step();
      chk("cap ramp", rd_adr[0], 32'h1C + 32'(i));
    end
    start(0, 32'h50, '1);
    ramp(32'h50, 15, 1);
    chk("p0 not done", 32'(done[0]), 32'd0);
    ramp(32'h5F, 1, 1);
    chk("p0 done", 32'(done[0]), 32'd1);
    rd_idx = 0;
    step();
    chk("p0 trig first", rd_adr[0], 32'h50);
    ramp(32'h60, 5, 1);
    start(4, 32'h108, '1);
    ramp(32'h100, 24, 5);
    chk("chg done", 32'(done[1]), 32'd1);
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      step();
      chk("chg entry", rd_adr[1], 32'h104 + 32'(i));
    end
    start(2, 32'h10, '1);
    ramp(0, 20, 1);
    chk("in post", 32'(st[0]), 32'd3);
    abort = 1;
    step();
    abort = 0;
    chk("abort post", 32'(st[0]), 32'd0);
    arm = 1;
    step();
    arm = 0;
    chk("rearm", 32'(st[0]), 32'd1);
    arm = 1;
    abort = 1;
    step();
    chk("arm+abort pre", 32'(st[0]), 32'd0);
    step();
    chk("arm+abort idle", 32'(st[0]), 32'd0);
    abort = 0;
    step();
    arm = 0;
    chk("restart", 32'(st[0]), 32'd1);
    ramp(0, 40, 1);
    chk("restart done", 32'(done[0]), 32'd1);
    for (int r = 0; r < 12; r++) begin
      start(4'($urandom_range(0, 15)), 32'($urandom_range(0, 31)), r[0] ? '1 : 32'($urandom_range(0, 31)));
      for (int c = 0; c < 100; c++) begin
        if ($urandom_range(0, 2) != 0) adr = 32'($urandom_range(0, 31));
        dat = $urandom;
        rd_idx = 4'($urandom_range(0, 15));
        abort = $urandom_range(0, 99) == 0;
        arm = $urandom_range(0, 39) == 0;
        rst = $urandom_range(0, 299) == 0;
        chk_pass("rand pass");
        step();
      end
      arm = 0;
      abort = 0;
      rst = 0;
    end
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ext_ram_trace_tap.md
EXT_RAM_TRACE_TAP -- requirements
Module: ext_ram_trace_tap

Interface
REQ-001 SHALL have parameter ADR_W, default 32, external RAM address width.
REQ-002 SHALL have parameter DAT_W, default 32, external RAM read-data width.
REQ-003 SHALL have parameter DEPTH_LOG2, default 9, trace depth DEPTH = 2**DEPTH_LOG2 entries.
REQ-004 SHALL have parameter DAT_LAT, default 1 (legal 0/1), RAM read latency in cycles.
REQ-005 SHALL have parameter CHANGE_ONLY, default 0, 1 = record only on address change.
REQ-006 SHALL have port sys_clk  in  1  sole clock; all state is rising-edge.
REQ-007 SHALL have port sys_rst  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port ext_ram_i_adr  in  ADR_W  address from CPU side.
REQ-009 SHALL have port ext_ram_i_dat_r  out  DAT_W  read data to CPU side.
REQ-010 SHALL have port ext_ram_o_adr  out  ADR_W  address to RAM.
REQ-011 SHALL have port ext_ram_o_dat_r  in  DAT_W  read data from RAM.
REQ-012 SHALL have port arm  in  1  single-cycle capture start.
REQ-013 SHALL have port abort  in  1  single-cycle capture cancel.
REQ-014 SHALL have port trig_adr  in  ADR_W  trigger address.
REQ-015 SHALL have port trig_mask  in  ADR_W  trigger compare mask (1 = compare bit).
REQ-016 SHALL have port pre_count  in  DEPTH_LOG2  pre-trigger sample count, sampled on arm.
REQ-017 SHALL have port state  out  3  FSM state code.
REQ-018 SHALL have port done  out  1  high in DONE.
REQ-019 SHALL have port rd_idx  in  DEPTH_LOG2  readout index, 0 = oldest entry.
REQ-020 SHALL have port rd_adr  out  ADR_W  readout address field.
REQ-021 SHALL have port rd_dat  out  DAT_W  readout data field.

Function
REQ-022 SHALL drive ext_ram_o_adr = ext_ram_i_adr and ext_ram_i_dat_r = ext_ram_o_dat_r combinationally, zero latency, independent of reset and FSM.
REQ-023 SHALL form sample pair {A, D}: D = ext_ram_o_dat_r current cycle; A = ext_ram_i_adr current cycle (DAT_LAT=0) or delayed one cycle (DAT_LAT=1).
REQ-024 SHALL qualify a sample every cycle when CHANGE_ONLY=0; when 1, only if A differs from previous cycle's A or first cycle after arm.
REQ-025 SHALL implement states IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4; done = (state==DONE).
REQ-026 SHALL, on arm in IDLE or DONE: latch P = pre_count, clear write pointer and counters, go to PRE (P>0) or WAIT (P=0); arm in other states ignored.
REQ-027 SHALL, in PRE, write each qualified sample at write pointer, increment pointer mod DEPTH, go to WAIT after P-th write; trigger not evaluated in PRE.
REQ-028 SHALL, in WAIT, write qualified samples circularly; trigger = qualified sample with (A & trig_mask) == (trig_adr & trig_mask).
REQ-029 SHALL, on trigger, write the trigger sample, set start pointer = trigger slot - P (mod DEPTH), set remaining = DEPTH-1-P, go to POST (remaining>0) or DONE.
REQ-030 SHALL, in POST, write qualified samples, decrement remaining per write, go to DONE on write making remaining 0.
REQ-031 SHALL perform no memory writes in IDLE or DONE.
REQ-032 SHALL give abort priority over arm and trigger: any state -> IDLE next cycle, no write that cycle.
REQ-033 SHALL register rd_adr/rd_dat = mem[(start pointer + rd_idx) mod DEPTH], 1-cycle latency, readable in every state; entry rd_idx=P is trigger sample after DONE.
REQ-034 SHALL keep buffer contents and start pointer after DONE until next trigger.

Reset
REQ-035 SHALL, during sys_rst, force state=IDLE, done=0, pointers/counters=0, rd_adr=0, rd_dat=0, address-change history invalid, DAT_LAT delay register=0; memory contents not reset.
REQ-036 SHALL, on reset mid-capture, abandon capture; buffer content undefined for readout until next DONE.

Verification
REQ-037 SHALL verify passthrough: ext_ram_i_adr=0x1234, ext_ram_o_dat_r=0xCAFE -> ext_ram_o_adr=0x1234, ext_ram_i_dat_r=0xCAFE same cycle, also during reset.
REQ-038 SHALL verify capture: DEPTH=16, DAT_LAT=0, pre_count=4, address ramp 0,1,2..., trig_adr=0x20 mask=0xFFFFFFFF -> DONE after address 0x2B; rd_idx 0..15 returns 0x1C..0x2B, rd_idx=4 returns 0x20.
REQ-039 SHALL verify pre_count=0 and trigger on first WAIT sample -> rd_idx=0 holds trigger, DONE after 16 samples.
REQ-040 SHALL verify CHANGE_ONLY=1: address held 5 cycles per value -> one entry per value, consecutive entries differ.
REQ-041 SHALL verify abort in POST -> state=0 next cycle, subsequent arm restarts, arm+abort same cycle -> IDLE.
REQ-042 SHALL verify DAT_LAT=1: address N with data N+0x100 one cycle later -> entries pair A=N with D=N+0x100.
